// File: rtl/fb_scanout_if.sv
// Framebuffer read bus plus renderer buffer-swap handshake for fb_scanout.
// master: the scanout engine (drives the read address and swap acknowledge).
// slave:  the memory/renderer side.
interface fb_scanout_if;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;
  logic        swap_req;
  logic        swap_ack;
  logic        buf_sel;

  modport master (
    output fb_addr,
    input  fb_data,
    input  swap_req,
    output swap_ack,
    output buf_sel
  );

  modport slave (
    input  fb_addr,
    output fb_data,
    output swap_req,
    input  swap_ack,
    input  buf_sel
  );
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer scanout engine.
// Generates a registered framebuffer read address from the screen position,
// maps the returned palette index through a 16-entry 12-bit palette and
// delays the timing signals so that colour and syncs line up RD_LAT+2 cycles
// after the timing inputs.
// Optional feature macro: SCANOUT_DOUBLE_BUFFER_EN enables double buffering
// (buffer base selection and frame-synchronous buffer swapping). Without it
// buf_sel is held 0 and swap_ack simply answers a request at each frame pulse.
module fb_scanout #(
  parameter int CORDW      = 10,
  parameter int H_RES      = 800,
  parameter int FB_HALF    = 1,
  parameter int RD_LAT     = 2,
  parameter int BUF_OFFSET = 240000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             frame,
  input  logic             pal_we,
  input  logic [3:0]       pal_idx,
  input  logic [11:0]      pal_data,
  output logic [3:0]       r,
  output logic [3:0]       g,
  output logic [3:0]       b,
  output logic             out_de,
  output logic             out_hsync,
  output logic             out_vsync,
  fb_scanout_if.master     fb
);

  localparam int NSTG = RD_LAT + 2;

  logic [18:0]            addr_q, addr_d;
  logic [18:0]            lin;
  logic [18:0]            base;
  logic [NSTG-1:0][2:0]   tim_q, tim_d;
  logic [15:0][11:0]      pal_q, pal_d;
  logic [11:0]            rgb_q, rgb_d;
  logic                   swap_ack_q, swap_ack_d;
  logic                   buf_sel_q, buf_sel_d;

`ifdef SCANOUT_DOUBLE_BUFFER_EN
  typedef enum logic {IDLE, PENDING} swap_state_e;
  swap_state_e state_q, state_d;
  logic        swap_fire;

  // Swap handshake state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Swap next state: a request arms PENDING unless it coincides with a frame pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (swap_req_in() && !frame) state_d = PENDING;
      PENDING: if (frame)                   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Swap outputs: toggle the buffer and acknowledge only on a frame pulse.
  always_comb begin
    swap_fire  = frame && ((state_q == PENDING) || swap_req_in());
    swap_ack_d = swap_fire;
    buf_sel_d  = buf_sel_q ^ swap_fire;
    base       = buf_sel_q ? 19'(BUF_OFFSET) : '0;
  end
`else
  // Single buffer: acknowledge a pending request at the frame pulse, never swap.
  always_comb begin
    swap_ack_d = frame && swap_req_in();
    buf_sel_d  = 1'b0;
    base       = '0;
  end
`endif

  function automatic logic swap_req_in();
    return fb.swap_req;
  endfunction

  // Address, timing delay line, palette update and colour lookup.
  always_comb begin
    lin    = 19'(sy) * 19'(H_RES) + 19'(sx);
    addr_d = base + (lin >> FB_HALF);
    tim_d  = {tim_q[NSTG-2:0], {de, hsync, vsync}};
    pal_d  = pal_q;
    if (pal_we) pal_d[pal_idx] = pal_data;
    // Stage RD_LAT carries the de that belongs to the fb_data arriving now.
    rgb_d  = tim_q[RD_LAT][2] ? pal_q[fb.fb_data] : '0;
  end

  // Datapath registers; reset loads a grey-ramp palette.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= '0;
      tim_q      <= '0;
      rgb_q      <= '0;
      swap_ack_q <= 1'b0;
      buf_sel_q  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) pal_q[i] <= {3{4'(i)}};
    end else begin
      addr_q     <= addr_d;
      tim_q      <= tim_d;
      rgb_q      <= rgb_d;
      swap_ack_q <= swap_ack_d;
      buf_sel_q  <= buf_sel_d;
      pal_q      <= pal_d;
    end
  end

  assign fb.fb_addr  = addr_q;
  assign fb.swap_ack = swap_ack_q;
  assign fb.buf_sel  = buf_sel_q;
  assign r           = rgb_q[11:8];
  assign g           = rgb_q[7:4];
  assign b           = rgb_q[3:0];
  assign out_de      = tim_q[NSTG-1][2];
  assign out_hsync   = tim_q[NSTG-1][1];
  assign out_vsync   = tim_q[NSTG-1][0];

endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout: directed checks with literal expectations plus
// randomized traffic compared every cycle against a history-based model.
module tb_fb_scanout;
  localparam int RD_LAT = 2;
  localparam int LAT    = RD_LAT + 2;
  localparam int H      = 800;
  localparam int FBH    = 1;
  localparam int OFF    = 240000;

`ifdef SCANOUT_DOUBLE_BUFFER_EN
  localparam logic EXP_BS  = 1'b1;
  localparam int   EXP_A00 = 240000;
`else
  localparam logic EXP_BS  = 1'b0;
  localparam int   EXP_A00 = 0;
`endif

  logic       clk, rst;
  logic [9:0] sx, sy;
  logic       de, hs, vs, frame;
  logic       pal_we;
  logic [3:0] pal_idx;
  logic [11:0] pal_data;
  logic [3:0] r, g, b;
  logic       out_de, out_hsync, out_vsync;

  fb_scanout_if ifc ();

  fb_scanout #(.CORDW(10), .H_RES(H), .FB_HALF(FBH), .RD_LAT(RD_LAT), .BUF_OFFSET(OFF)) dut (
    .clk(clk), .rst(rst), .sx(sx), .sy(sy), .de(de), .hsync(hs), .vsync(vs),
    .frame(frame), .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .r(r), .g(g), .b(b), .out_de(out_de), .out_hsync(out_hsync),
    .out_vsync(out_vsync), .fb(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer memory model with RD_LAT cycles of read latency.
  logic [3:0]  fbm [4096];
  logic [18:0] mp  [RD_LAT];
  initial for (int k = 0; k < RD_LAT; k++) mp[k] = '0;
  always @(posedge clk) begin
    mp[0] <= ifc.fb_addr;
    for (int k = 1; k < RD_LAT; k++) mp[k] <= mp[k-1];
  end
  assign ifc.fb_data = fbm[mp[RD_LAT-1][11:0]];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs after edge n derive from the input
  // history of edges n-(LAT-1)..n and the palette/buffer state before edge n.
  logic        hr [8];
  logic [2:0]  ht [8];
  logic [18:0] ha [8];
  logic [11:0] pm [16];
  logic        bs, pend;
  logic [18:0] e_addr;
  logic [2:0]  e_tim;
  logic [11:0] e_rgb;
  logic        e_ack;

  initial begin : model
    int n, i, j;
    logic okp;
    n = 0;
    bs = 1'b0;
    pend = 1'b0;
    for (int k = 0; k < 8; k++) begin hr[k] = 1'b0; ht[k] = '0; ha[k] = '0; end
    for (int k = 0; k < 16; k++) pm[k] = '0;
    forever begin
      @(posedge clk);
      i = n % 8;
      j = (n + 8 - (LAT - 1)) % 8;
      hr[i] = rst;
      ht[i] = {de, hs, vs};
      okp = 1'b1;
      for (int k = 0; k < LAT; k++) if (!hr[(n + 8 - k) % 8]) okp = 1'b0;
      if (!rst) begin
        e_addr = '0; e_tim = '0; e_rgb = '0; e_ack = 1'b0;
        bs = 1'b0; pend = 1'b0;
        for (int k = 0; k < 16; k++) pm[k] = {3{4'(k)}};
      end else begin
        e_addr = 19'((bs ? OFF : 0) + ((int'(sy) * H + int'(sx)) >> FBH));
        if (okp) begin
          e_tim = ht[j];
          e_rgb = ht[j][2] ? pm[fbm[ha[j][11:0]]] : 12'h000;
        end else begin
          e_tim = '0;
          e_rgb = '0;
        end
        if (pal_we) pm[pal_idx] = pal_data;
`ifdef SCANOUT_DOUBLE_BUFFER_EN
        if (frame && (pend || ifc.swap_req)) begin
          bs = ~bs; e_ack = 1'b1; pend = 1'b0;
        end else begin
          e_ack = 1'b0;
          if (ifc.swap_req) pend = 1'b1;
        end
`else
        e_ack = frame & ifc.swap_req;
`endif
      end
      ha[i] = e_addr;
      @(negedge clk);
      check("fb_addr",   32'(ifc.fb_addr), 32'(e_addr));
      check("out_de",    32'(out_de),      32'(e_tim[2]));
      check("out_hsync", 32'(out_hsync),   32'(e_tim[1]));
      check("out_vsync", 32'(out_vsync),   32'(e_tim[0]));
      check("rgb",       32'({r, g, b}),   32'(e_rgb));
      check("swap_ack",  32'(ifc.swap_ack), 32'(e_ack));
      check("buf_sel",   32'(ifc.buf_sel), 32'(bs));
      n++;
    end
  end

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin : stim
    rst = 1'b0; sx = '0; sy = '0; de = 0; hs = 0; vs = 0; frame = 0;
    pal_we = 0; pal_idx = '0; pal_data = '0; ifc.swap_req = 1'b0;
    for (int k = 0; k < 4096; k++) fbm[k] = 4'($urandom_range(0, 15));
    wait_neg(3);
    check("reset_rgb", 32'({r, g, b}), 32'h0);
    check("reset_addr", 32'(ifc.fb_addr), 32'h0);

    // Address generation.
    rst = 1'b1; sx = 10'd5; sy = 10'd3;
    wait_neg(1);
    check("addr_5_3", 32'(ifc.fb_addr), 32'd1202);
    sx = 10'd799; sy = 10'd599;
    wait_neg(1);
    check("addr_799_599", 32'(ifc.fb_addr), 32'd239999);

    // Pipeline latency and palette lookup: (10,2) -> word 805.
    fbm[805] = 4'h7; sx = 10'd10; sy = 10'd2; de = 1;
    wait_neg(1);
    sx = 10'd12; de = 0;
    wait_neg(2);
    check("de_not_early", 32'(out_de), 32'h0);
    wait_neg(1);
    check("pix_777", 32'({r, g, b}), 32'h777);
    check("de_at_4", 32'(out_de), 32'h1);
    wait_neg(1);
    check("pix_blank", 32'({r, g, b}), 32'h0);
    check("de_off", 32'(out_de), 32'h0);

    // Palette write colliding with a lookup of the same index.
    fbm[810] = 4'h7; fbm[811] = 4'h7; sx = 10'd20; sy = 10'd2; de = 1;
    wait_neg(1);
    sx = 10'd22;
    wait_neg(1);
    de = 0; sx = 10'd30;
    wait_neg(1);
    pal_we = 1; pal_idx = 4'd7; pal_data = 12'hF00;
    wait_neg(1);
    pal_we = 0;
    check("collide_old", 32'({r, g, b}), 32'h777);
    wait_neg(1);
    check("collide_new", 32'({r, g, b}), 32'hF00);

    // Swap request mid-frame; takes effect only at the frame pulse.
    ifc.swap_req = 1'b1;
    wait_neg(1);
    check("swap_wait_ack", 32'(ifc.swap_ack), 32'h0);
    check("swap_wait_bs", 32'(ifc.buf_sel), 32'h0);
    wait_neg(2);
    check("swap_hold_ack", 32'(ifc.swap_ack), 32'h0);
    check("swap_hold_bs", 32'(ifc.buf_sel), 32'h0);
    frame = 1;
    wait_neg(1);
    frame = 0;
    check("swap_ack_hi", 32'(ifc.swap_ack), 32'h1);
    check("swap_bs", 32'(ifc.buf_sel), 32'(EXP_BS));
    ifc.swap_req = 1'b0; sx = '0; sy = '0;
    wait_neg(1);
    check("swap_ack_lo", 32'(ifc.swap_ack), 32'h0);
    check("addr_00", 32'(ifc.fb_addr), 32'(EXP_A00));

    // Reset for one cycle in the middle of active pixels.
    for (int k = 0; k < 5; k++) begin
      de = 1; sx = 10'(40 + k); sy = 10'd10;
      wait_neg(1);
    end
    rst = 1'b0;
    wait_neg(1);
    check("rst_addr", 32'(ifc.fb_addr), 32'h0);
    check("rst_rgb", 32'({r, g, b}), 32'h0);
    check("rst_de", 32'(out_de), 32'h0);
    check("rst_bs", 32'(ifc.buf_sel), 32'h0);
    check("rst_ack", 32'(ifc.swap_ack), 32'h0);
    rst = 1'b1; sx = 10'd100; sy = 10'd50; de = 1; fbm[3666] = 4'h9;
    wait_neg(1);
    de = 0; sx = 10'd101;
    wait_neg(2);
    check("resume_early", 32'(out_de), 32'h0);
    wait_neg(1);
    check("resume_de", 32'(out_de), 32'h1);
    check("resume_rgb", 32'({r, g, b}), 32'h999);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      wait_neg(1);
      rst      = ($urandom_range(0, 199) != 0);
      sx       = 10'($urandom_range(0, 799));
      sy       = 10'($urandom_range(0, 599));
      de       = ($urandom_range(0, 3) != 0);
      hs       = 1'($urandom_range(0, 1));
      vs       = 1'($urandom_range(0, 1));
      frame    = ($urandom_range(0, 29) == 0);
      pal_we   = ($urandom_range(0, 7) == 0);
      pal_idx  = 4'($urandom_range(0, 15));
      pal_data = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) == 0) ifc.swap_req = ~ifc.swap_req;
      if (ifc.swap_ack && $urandom_range(0, 1) == 1) ifc.swap_req = 1'b0;
    end

    wait_neg(1);
    rst = 1'b1; de = 0; hs = 0; vs = 0; frame = 0; pal_we = 0; ifc.swap_req = 1'b0;
    wait_neg(LAT + 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 The block SHALL have parameter CORDW, default 10, screen coordinate width.
REQ-002 The block SHALL have parameter H_RES, default 800, framebuffer line pitch in pixels.
REQ-003 The block SHALL have parameter FB_HALF, default 1; when 1, each framebuffer word is shown for two horizontally adjacent pixels.
REQ-004 The block SHALL have parameter RD_LAT, default 2, range 1-3, framebuffer read latency in cycles.
REQ-005 The block SHALL have parameter BUF_OFFSET, default 240000, word offset of buffer 1.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit, reset that is synchronous and active-low.
REQ-008 The block SHALL have port sx, sy, input, CORDW bits each, current screen position from the timing generator.
REQ-009 The block SHALL have port de, hsync, vsync, input, 1 bit each, display enable and syncs aligned with sx/sy.
REQ-010 The block SHALL have port frame, input, 1 bit, one-cycle pulse at frame start (first blanking cycle).
REQ-011 The block SHALL have port fb_addr, output, 19 bits, framebuffer read address.
REQ-012 The block SHALL have port fb_data, input, 4 bits, palette index returned RD_LAT cycles after fb_addr.
REQ-013 The block SHALL have ports pal_we (1 bit), pal_idx (4 bits) and pal_data (12 bits), inputs, used to write a palette entry.
REQ-014 The block SHALL have ports r, g, b, output, 4 bits each, pixel colour.
REQ-015 The block SHALL have ports out_de, out_hsync, out_vsync, output, 1 bit each, delayed copies of the timing inputs.
REQ-016 The block SHALL have ports swap_req (input, 1 bit), swap_ack (output, 1 bit) and buf_sel (output, 1 bit) for the renderer buffer handshake.

Function
REQ-017 fb_addr SHALL be registered: base + ((sy*H_RES + sx) >> FB_HALF), where base = buf_sel ? BUF_OFFSET : 0; sum computed at 19 bits and truncated to 19 bits.
REQ-018 fb_addr SHALL update every cycle regardless of de.
REQ-019 Pipeline latency from sx/sy/de/hsync/vsync input to r/g/b/out_* output SHALL be exactly RD_LAT+2 cycles.
REQ-020 out_de, out_hsync and out_vsync SHALL be delayed through a shift register of RD_LAT+2 stages.
REQ-021 r/g/b SHALL be the registered palette[fb_data] when the delayed de is 1, and 0 otherwise.
REQ-022 The palette SHALL be 16 x 12-bit registers; {r,g,b} = entry[11:8], [7:4], [3:0].
REQ-023 On pal_we=1 the palette SHALL write entry pal_idx with pal_data at that edge; a lookup of the same index in that cycle returns the old value, and the new value is used from the next cycle.
REQ-024 The swap handshake SHALL have states IDLE and PENDING; swap_req=1 in IDLE moves to PENDING.
REQ-025 On frame=1 while in PENDING, or with swap_req=1 in IDLE, buf_sel SHALL toggle, swap_ack SHALL pulse high for exactly one cycle, and the state SHALL return to IDLE.
REQ-026 buf_sel SHALL change only on a frame pulse, never mid-frame.
REQ-027 swap_ack SHALL be one cycle per toggle; the renderer deasserts swap_req on swap_ack, and swap_req still high after an ack SHALL re-arm for the next frame.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL set fb_addr=0, r=g=b=0, out_de=out_hsync=out_vsync=0, swap_ack=0, buf_sel=0, state=IDLE, all delay stages=0, and palette entry i={i,i,i} (grey ramp).
REQ-029 Reset asserted mid-frame SHALL take effect at the next edge, discarding in-flight pixels; the first valid output appears RD_LAT+2 cycles after release.

Configuration
REQ-030 With macro SCANOUT_DOUBLE_BUFFER_EN defined, the block SHALL implement REQ-017 base selection and REQ-024..027 buffer toggling.
REQ-031 Without SCANOUT_DOUBLE_BUFFER_EN, buf_sel SHALL be tied 0 and base SHALL be 0; swap_ack SHALL still pulse one cycle on a frame pulse while swap_req=1, so the renderer never stalls.

Verification
REQ-032 Verification SHALL cover address generation: RD_LAT=2, FB_HALF=1, sx=5, sy=3, buf_sel=0 -> fb_addr=1202 one cycle later; sx=799, sy=599 -> 239999.
REQ-033 Verification SHALL cover the pipeline and palette path: de pulse with fb_data=4'h7 and the reset palette -> rgb=12'h777 and out_de=1 exactly 4 cycles after the input; de=0 -> rgb=0.
REQ-034 Verification SHALL cover a palette write collision: pal_we with idx 7, data 12'hF00, in the same cycle as a lookup of index 7 -> that pixel is 12'h777 and the next is 12'hF00.
REQ-035 Verification SHALL cover a swap (macro on): swap_req raised mid-frame -> no change until frame; at frame, buf_sel 0->1, swap_ack high one cycle, next fb_addr for (0,0) = 240000.
REQ-036 Verification SHALL cover swap with the macro off: swap_req high and frame pulse -> swap_ack one cycle, buf_sel stays 0, fb_addr for (0,0) = 0.
REQ-037 Verification SHALL cover reset mid-frame: rst=0 for 1 cycle with buf_sel=1 and active pixels -> all outputs 0 and buf_sel=0 next edge; valid output resumes 4 cycles after release.
